// File: rtl/pc_fetch_unit.sv
// IF-stage program counter: decodes the MEM-stage control transfer, holds a
// resolved redirect across pcen stalls, freezes on halt and counts redirects.
module pc_fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             pcen,
    input  logic             halt,
    input  logic [2:0]       mem_pcsrc,
    input  logic             mem_zero,
    input  logic [31:0]      mem_btarget,
    input  logic [31:0]      mem_jtarget,
    input  logic [31:0]      mem_jrtarget,
    output logic [31:0]      imemaddr,
    output logic             imemREN,
    output logic [31:0]      pc_plus4,
    output logic             redirect,
    output logic             pending,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic        taken;
    logic [31:0] target;

    always_comb begin
        taken  = 1'b0;
        target = mem_btarget;
        unique case (mem_pcsrc)
            3'd1: begin taken = mem_zero;  target = mem_btarget;  end
            3'd2: begin taken = ~mem_zero; target = mem_btarget;  end
            3'd3: begin taken = 1'b1;      target = mem_jtarget;  end
            3'd4: begin taken = 1'b1;      target = mem_jrtarget; end
            default: begin taken = 1'b0;   target = mem_btarget;  end
        endcase
    end

    // Only a RUN-state resolution is genuine; in PEND the MEM instruction is wrong-path.
    assign redirect = taken && (state == RUN);

    assign imemaddr = pc;
    assign pc_plus4 = pc + 32'd4;
    assign imemREN  = (state != HALT);
    assign pending  = (state == PEND);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= RUN;
            pc             <= PC_INIT;
            pend_pc        <= '0;
            redirect_count <= '0;
        end else if (halt) begin
            state <= HALT;
        end else begin
            unique case (state)
                RUN: begin
                    if (redirect && pcen) begin
                        pc <= target;
                        if (redirect_count != '1)
                            redirect_count <= redirect_count + 1'b1;
                    end else if (redirect) begin
                        pend_pc <= target;
                        state   <= PEND;
                    end else if (pcen) begin
                        pc <= pc + 32'd4;
                    end
                end
                PEND: begin
                    if (pcen) begin
                        pc    <= pend_pc;
                        state <= RUN;
                        if (redirect_count != '1)
                            redirect_count <= redirect_count + 1'b1;
                    end
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule
